// File: rtl/vxc_chunk_sequencer_if.sv
// Read, datapath and write-back bus between vxc_chunk_sequencer (master) and
// the row memories / MAC datapath (slave).
interface vxc_chunk_sequencer_if #(
    parameter int unsigned NI            = 8,
    parameter int unsigned ELEMENT_WIDTH = 64,
    parameter int unsigned AW            = 8
);
    localparam int unsigned ROW_W = ELEMENT_WIDTH * NI;

    logic                     rd_en;
    logic [AW-1:0]            rd_addr;
    logic [ROW_W-1:0]         x_rd_data;
    logic [ROW_W-1:0]         y_rd_data;
    logic [ROW_W-1:0]         first_row_out;
    logic [ROW_W-1:0]         second_row_out;
    logic [ELEMENT_WIDTH-1:0] constant_out;
    logic                     op_out;
    logic [ROW_W-1:0]         result_in;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [ROW_W-1:0]         wr_data;
    logic [NI-1:0]            wr_mask;

    modport master (
        output rd_en, rd_addr, first_row_out, second_row_out,
               constant_out, op_out, wr_en, wr_addr, wr_data, wr_mask,
        input  x_rd_data, y_rd_data, result_in
    );

    modport slave (
        input  rd_en, rd_addr, first_row_out, second_row_out,
               constant_out, op_out, wr_en, wr_addr, wr_data, wr_mask,
        output x_rd_data, y_rd_data, result_in
    );
endinterface

// File: rtl/vxc_chunk_sequencer.sv
// Chunk sequencer for the 8-lane complex MAC datapath: streams NI-element
// chunks of x/y through the datapath back-to-back and writes results back.
// Optional feature macro: VXC_SEQ_PAD_MASK_EN (zero and write-mask the lanes
// of the final chunk that lie beyond NOE).
module vxc_chunk_sequencer #(
    parameter int unsigned NOE           = 19,
    parameter int unsigned NI            = 8,
    parameter int unsigned ELEMENT_WIDTH = 64,
    parameter int unsigned LAT           = 7,
    parameter int unsigned AW            = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ELEMENT_WIDTH-1:0] constant_in,
    input  logic                     op_in,
    output logic                     busy,
    output logic                     done,
    vxc_chunk_sequencer_if.master    bus
);
    localparam int unsigned EW     = ELEMENT_WIDTH;
    localparam int unsigned ROW_W  = EW * NI;
    localparam int unsigned NCHUNK = (NOE + NI - 1) / NI;
    localparam int unsigned LAST   = NCHUNK - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_nxt;
    logic           rd_en_q, rd_en_nxt;
    logic [AW-1:0]  rd_addr_q, rd_addr_nxt;
    logic           done_q, done_nxt;
    logic           busy_q, busy_nxt;
    logic [EW-1:0]  const_q, const_nxt;
    logic           op_q, op_nxt;

    // in-flight tracker: stage 0 is the cycle row data is on the datapath inputs
    logic [LAT:0]   vld_q;
    logic [AW-1:0]  addr_q [LAT+1];

    logic           wr_en_q;
    logic [AW-1:0]  wr_addr_q;
    logic [ROW_W-1:0] wr_data_q;
    logic [NI-1:0]  wr_mask_q;

    logic [NI-1:0]  rd_keep_c;
    logic [NI-1:0]  wr_keep_c;
    logic [ROW_W-1:0] first_row_c;
    logic [ROW_W-1:0] second_row_c;

`ifdef VXC_SEQ_PAD_MASK_EN
    // lane k is live when its element index is inside the vector; lane 0 is the MSB
    function automatic logic [NI-1:0] lane_keep(input logic [AW-1:0] chunk);
        logic [NI-1:0] keep;
        keep = '0;
        for (int unsigned k = 0; k < NI; k++) begin
            if (32'(chunk) * NI + k < NOE) begin
                keep[NI-1-k] = 1'b1;
            end
        end
        return keep;
    endfunction

    assign rd_keep_c = lane_keep(addr_q[0]);
    assign wr_keep_c = lane_keep(addr_q[LAT]);
`else
    assign rd_keep_c = '1;
    assign wr_keep_c = '1;
`endif

    // control state and registered control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            const_q   <= '0;
            op_q      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            rd_en_q   <= rd_en_nxt;
            rd_addr_q <= rd_addr_nxt;
            done_q    <= done_nxt;
            busy_q    <= busy_nxt;
            const_q   <= const_nxt;
            op_q      <= op_nxt;
        end
    end

    // next state: issue one read per cycle, then wait for the pipeline to empty
    always_comb begin
        state_nxt   = state_q;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = rd_addr_q;
        done_nxt    = 1'b0;
        busy_nxt    = busy_q;
        const_nxt   = const_q;
        op_nxt      = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_ISSUE;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    busy_nxt    = 1'b1;
                    const_nxt   = constant_in;
                    op_nxt      = op_in;
                end
            end
            S_ISSUE: begin
                if (rd_addr_q == AW'(LAST)) begin
                    state_nxt = S_DRAIN;
                end else begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (vld_q == '0) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // valid/address shift register following each read through memory and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q     <= {vld_q[LAT-1:0], rd_en_q};
            addr_q[0] <= rd_addr_q;
            for (int unsigned i = 1; i <= LAT; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    // capture the datapath result for the chunk leaving the last stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
        end else begin
            wr_en_q <= vld_q[LAT];
            if (vld_q[LAT]) begin
                wr_addr_q <= addr_q[LAT];
                wr_data_q <= bus.result_in;
                wr_mask_q <= wr_keep_c;
            end
        end
    end

    // row data straight to the datapath; idle and dropped lanes read as zero
    always_comb begin
        first_row_c  = '0;
        second_row_c = '0;
        for (int unsigned k = 0; k < NI; k++) begin
            if (vld_q[0] && rd_keep_c[NI-1-k]) begin
                first_row_c[EW*(NI-k)-1 -: EW]  = bus.x_rd_data[EW*(NI-k)-1 -: EW];
                second_row_c[EW*(NI-k)-1 -: EW] = bus.y_rd_data[EW*(NI-k)-1 -: EW];
            end
        end
    end

    assign bus.rd_en          = rd_en_q;
    assign bus.rd_addr        = rd_addr_q;
    assign bus.first_row_out  = first_row_c;
    assign bus.second_row_out = second_row_c;
    assign bus.constant_out   = const_q;
    assign bus.op_out         = op_q;
    assign bus.wr_en          = wr_en_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_data        = wr_data_q;
    assign bus.wr_mask        = wr_mask_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
// Bench for vxc_chunk_sequencer: two instances (NOE=19 with a padded final
// chunk, NOE=16 without), emulated row memories and a real-valued complex MAC
// datapath with LAT cycles of latency, checked against cycle/value rules.
module tb_vxc_chunk_sequencer;
    localparam int unsigned NI    = 8;
    localparam int unsigned EW    = 64;
    localparam int unsigned LAT   = 7;
    localparam int unsigned AW    = 8;
    localparam int unsigned ROW_W = EW * NI;
    localparam int unsigned MAXE  = 24;
    localparam int          END_REL = 3 + 3 + LAT + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [EW-1:0] constant_in;
    logic          op_in;
    logic          busy_a, done_a, busy_b, done_b;

    int n_checks = 0;
    int n_fails  = 0;

    vxc_chunk_sequencer_if #(.NI(NI), .ELEMENT_WIDTH(EW), .AW(AW)) bus_a ();
    vxc_chunk_sequencer_if #(.NI(NI), .ELEMENT_WIDTH(EW), .AW(AW)) bus_b ();

    vxc_chunk_sequencer #(.NOE(19), .NI(NI), .ELEMENT_WIDTH(EW), .LAT(LAT), .AW(AW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .constant_in(constant_in),
        .op_in(op_in), .busy(busy_a), .done(done_a), .bus(bus_a)
    );
    vxc_chunk_sequencer #(.NOE(16), .NI(NI), .ELEMENT_WIDTH(EW), .LAT(LAT), .AW(AW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .constant_in(constant_in),
        .op_in(op_in), .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // per-instance views of the outputs, index 0 = NOE 19, 1 = NOE 16
    logic             o_rd_en[2], o_wr_en[2], o_done[2], o_busy[2], o_op[2];
    logic [AW-1:0]    o_rd_addr[2], o_wr_addr[2];
    logic [ROW_W-1:0] o_first[2], o_second[2], o_wr_data[2];
    logic [EW-1:0]    o_const[2];
    logic [NI-1:0]    o_mask[2];

    assign o_rd_en[0]   = bus_a.rd_en;          assign o_rd_en[1]   = bus_b.rd_en;
    assign o_wr_en[0]   = bus_a.wr_en;          assign o_wr_en[1]   = bus_b.wr_en;
    assign o_done[0]    = done_a;               assign o_done[1]    = done_b;
    assign o_busy[0]    = busy_a;               assign o_busy[1]    = busy_b;
    assign o_op[0]      = bus_a.op_out;         assign o_op[1]      = bus_b.op_out;
    assign o_rd_addr[0] = bus_a.rd_addr;        assign o_rd_addr[1] = bus_b.rd_addr;
    assign o_wr_addr[0] = bus_a.wr_addr;        assign o_wr_addr[1] = bus_b.wr_addr;
    assign o_first[0]   = bus_a.first_row_out;  assign o_first[1]   = bus_b.first_row_out;
    assign o_second[0]  = bus_a.second_row_out; assign o_second[1]  = bus_b.second_row_out;
    assign o_wr_data[0] = bus_a.wr_data;        assign o_wr_data[1] = bus_b.wr_data;
    assign o_const[0]   = bus_a.constant_out;   assign o_const[1]   = bus_b.constant_out;
    assign o_mask[0]    = bus_a.wr_mask;        assign o_mask[1]    = bus_b.wr_mask;

    logic [EW-1:0] mx [2][MAXE];
    logic [EW-1:0] my [2][MAXE];

    function automatic int noe_of(input int i);
        return (i == 0) ? 19 : 16;
    endfunction

    function automatic int chunks_of(input int i);
        return (noe_of(i) + NI - 1) / NI;
    endfunction

    function automatic string tg(input string n, input int i);
        return {n, (i == 0) ? "/noe19" : "/noe16"};
    endfunction

    // IEEE single <-> real for normal numbers and zero
    function automatic real f2r(input logic [31:0] b);
        real r;
        int  ex;
        if (b[30:0] == 31'd0) return 0.0;
        r  = 1.0 + real'(b[22:0]) / 8388608.0;
        ex = int'(b[30:23]) - 127;
        for (int j = 0; j < 130; j++) begin
            if (ex > 0) begin r = r * 2.0; ex--; end
            else if (ex < 0) begin r = r / 2.0; ex++; end
        end
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real a;
        int  ex;
        logic s;
        if (r == 0.0) return 32'd0;
        s  = (r < 0.0);
        a  = s ? -r : r;
        ex = 127;
        for (int j = 0; j < 130; j++) begin
            if (a >= 2.0) begin a = a / 2.0; ex++; end
            else if (a < 1.0) begin a = a * 2.0; ex--; end
        end
        return {s, 8'(ex), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    // result = y +/- conj(x) * k for one complex lane {re, im}
    function automatic logic [EW-1:0] dp_lane(input logic [EW-1:0] x, input logic [EW-1:0] y,
                                              input logic [EW-1:0] k, input logic op);
        real xr, xi, yr, yi, kr, ki, pr, pi;
        xr = f2r(x[63:32]); xi = f2r(x[31:0]);
        yr = f2r(y[63:32]); yi = f2r(y[31:0]);
        kr = f2r(k[63:32]); ki = f2r(k[31:0]);
        pr = xr * kr + xi * ki;
        pi = xr * ki - xi * kr;
        return op ? {r2f(yr - pr), r2f(yi - pi)} : {r2f(yr + pr), r2f(yi + pi)};
    endfunction

    function automatic logic [ROW_W-1:0] dp_chunk(input logic [ROW_W-1:0] x, input logic [ROW_W-1:0] y,
                                                  input logic [EW-1:0] k, input logic op);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k2 = 0; k2 < NI; k2++) begin
            r[ROW_W-1-k2*EW -: EW] = dp_lane(x[ROW_W-1-k2*EW -: EW], y[ROW_W-1-k2*EW -: EW], k, op);
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] rand_elem();
        return {r2f(real'(int'($urandom_range(6)) - 3)), r2f(real'(int'($urandom_range(6)) - 3))};
    endfunction

    function automatic logic [ROW_W-1:0] rand_chunk();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < NI; k++) r[ROW_W-1-k*EW -: EW] = rand_elem();
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] mem_chunk(input int i, input logic [AW-1:0] a, input bit yside);
        logic [ROW_W-1:0] r;
        int e;
        r = '0;
        for (int k = 0; k < NI; k++) begin
            e = int'(a) * NI + k;
            if (e < MAXE) r[ROW_W-1-k*EW -: EW] = yside ? my[i][e] : mx[i][e];
        end
        return r;
    endfunction

    function automatic bit lane_dropped(input int i, input int e);
`ifdef VXC_SEQ_PAD_MASK_EN
        return e >= noe_of(i);
`else
        return (i < 0) && (e < 0);
`endif
    endfunction

    // expected datapath input row for chunk c
    function automatic logic [ROW_W-1:0] exp_row(input int i, input int c, input bit yside);
        logic [ROW_W-1:0] r;
        int e;
        r = '0;
        for (int k = 0; k < NI; k++) begin
            e = c * NI + k;
            if (!lane_dropped(i, e)) r[ROW_W-1-k*EW -: EW] = yside ? my[i][e] : mx[i][e];
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] exp_wr(input int i, input int c, input logic [EW-1:0] k,
                                                input logic op, input bit directed);
        logic [ROW_W-1:0] r;
        r = dp_chunk(exp_row(i, c, 1'b0), exp_row(i, c, 1'b1), k, op);
        if (directed) begin
            for (int l = 0; l < NI; l++) begin
                if (!lane_dropped(i, c * NI + l))
                    r[ROW_W-1-l*EW -: EW] = op ? 64'h40000000_BF800000 : 64'h40000000_3F800000;
            end
        end
        return r;
    endfunction

    function automatic logic [NI-1:0] exp_mask(input int i, input int c);
        logic [NI-1:0] m;
        for (int l = 0; l < NI; l++) m[NI-1-l] = !lane_dropped(i, c * NI + l);
        return m;
    endfunction

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // emulated memories and datapath for both instances
    logic [ROW_W-1:0] dp_a [LAT];
    logic [ROW_W-1:0] dp_b [LAT];

    always @(posedge clk) begin
        bus_a.x_rd_data <= bus_a.rd_en ? mem_chunk(0, bus_a.rd_addr, 1'b0) : rand_chunk();
        bus_a.y_rd_data <= bus_a.rd_en ? mem_chunk(0, bus_a.rd_addr, 1'b1) : rand_chunk();
        bus_b.x_rd_data <= bus_b.rd_en ? mem_chunk(1, bus_b.rd_addr, 1'b0) : rand_chunk();
        bus_b.y_rd_data <= bus_b.rd_en ? mem_chunk(1, bus_b.rd_addr, 1'b1) : rand_chunk();
        dp_a[0] <= dp_chunk(bus_a.first_row_out, bus_a.second_row_out, bus_a.constant_out, bus_a.op_out);
        dp_b[0] <= dp_chunk(bus_b.first_row_out, bus_b.second_row_out, bus_b.constant_out, bus_b.op_out);
        for (int j = 1; j < LAT; j++) begin
            dp_a[j] <= dp_a[j-1];
            dp_b[j] <= dp_b[j-1];
        end
    end

    assign bus_a.result_in = dp_a[LAT-1];
    assign bus_b.result_in = dp_b[LAT-1];

    task automatic zero_check(input int i);
        check(tg("rst_rd_en", i),   ROW_W'(o_rd_en[i]),   '0);
        check(tg("rst_rd_addr", i), ROW_W'(o_rd_addr[i]), '0);
        check(tg("rst_wr_en", i),   ROW_W'(o_wr_en[i]),   '0);
        check(tg("rst_wr_addr", i), ROW_W'(o_wr_addr[i]), '0);
        check(tg("rst_wr_data", i), o_wr_data[i],         '0);
        check(tg("rst_wr_mask", i), ROW_W'(o_mask[i]),    '0);
        check(tg("rst_first", i),   o_first[i],           '0);
        check(tg("rst_second", i),  o_second[i],          '0);
        check(tg("rst_const", i),   ROW_W'(o_const[i]),   '0);
        check(tg("rst_op", i),      ROW_W'(o_op[i]),      '0);
        check(tg("rst_done", i),    ROW_W'(o_done[i]),    '0);
        check(tg("rst_busy", i),    ROW_W'(o_busy[i]),    '0);
    endtask

    // per-cycle expectations; rel is the cycle number counted from the start cycle
    task automatic check_cycle(input int i, input int rel, input bit dead,
                               input logic [EW-1:0] k, input logic op, input bit directed);
        int  c_n;
        bit  e_rd, e_wr;
        c_n  = chunks_of(i);
        e_rd = !dead && rel >= 1 && rel <= c_n;
        e_wr = !dead && rel >= 3 + LAT && rel <= 2 + LAT + c_n;
        check(tg("rd_en", i), ROW_W'(o_rd_en[i]), ROW_W'(e_rd));
        if (e_rd) check(tg("rd_addr", i), ROW_W'(o_rd_addr[i]), ROW_W'(rel - 1));
        if (!dead && rel >= 2 && rel <= c_n + 1) begin
            check(tg("first_row", i),  o_first[i],  exp_row(i, rel - 2, 1'b0));
            check(tg("second_row", i), o_second[i], exp_row(i, rel - 2, 1'b1));
        end
        check(tg("wr_en", i), ROW_W'(o_wr_en[i]), ROW_W'(e_wr));
        if (e_wr) begin
            check(tg("wr_addr", i), ROW_W'(o_wr_addr[i]), ROW_W'(rel - 3 - LAT));
            check(tg("wr_data", i), o_wr_data[i], exp_wr(i, rel - 3 - int'(LAT), k, op, directed));
            check(tg("wr_mask", i), ROW_W'(o_mask[i]), ROW_W'(exp_mask(i, rel - 3 - int'(LAT))));
        end
        check(tg("done", i), ROW_W'(o_done[i]), ROW_W'(!dead && rel == 3 + LAT + c_n));
        check(tg("busy", i), ROW_W'(o_busy[i]), ROW_W'(!dead && rel <= 3 + LAT + c_n));
        if (!dead) begin
            check(tg("constant_out", i), ROW_W'(o_const[i]), ROW_W'(k));
            check(tg("op_out", i), ROW_W'(o_op[i]), ROW_W'(op));
        end
    endtask

    task automatic run_op(input logic [EW-1:0] k, input logic op, input bit directed,
                          input bit restart, input bit rst_mid);
        bit dead;
        for (int i = 0; i < 2; i++) begin
            for (int e = 0; e < MAXE; e++) begin
                mx[i][e] = directed ? 64'h3F800000_00000000 : rand_elem();
                my[i][e] = directed ? 64'h40000000_00000000 : rand_elem();
            end
        end
        @(negedge clk);
        start       = 1'b1;
        constant_in = k;
        op_in       = op;
        for (int rel = 1; rel <= END_REL; rel++) begin
            @(negedge clk);
            dead = rst_mid && rel > 8;
            for (int i = 0; i < 2; i++) check_cycle(i, rel, dead, k, op, directed);
            if (rel == 1) begin
                start       = 1'b0;
                constant_in = rand_elem();
                op_in       = ~op;
            end
            if (restart && rel == 5) start = 1'b1;
            if (rel == 6) start = 1'b0;
            if (rst_mid && rel == 8) begin
                reset = 1'b0;
                #1;
                zero_check(0);
                zero_check(1);
            end
        end
        if (rst_mid) begin
            @(negedge clk);
            reset = 1'b1;
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        constant_in = '0;
        op_in       = 1'b0;
        repeat (3) @(negedge clk);
        zero_check(0);
        zero_check(1);
        reset = 1'b1;
        @(negedge clk);

        run_op(64'h00000000_3F800000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(64'h00000000_3F800000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(rand_elem(), 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
        run_op(rand_elem(), 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
        run_op(rand_elem(), 1'($urandom_range(1)), 1'b0, 1'b0, 1'b1);
        run_op(rand_elem(), 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
        run_op(rand_elem(), 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
